// File: rtl/memory_tank_sequencer.sv
// Access sequencer for one EDSAC mercury delay-line tank (32 short words, 18 digits each).
// Optional macro MEM_SEQ_MONITOR_EN enables the once-per-circulation monitor_sync pulse.
module memory_tank_sequencer #(
   parameter int WORD_BITS = 18,
   parameter int WORDS     = 32,
   parameter int ADDR_W    = 5
) (
   input  logic              f1_clk,
   input  logic              f1_rst,
   input  logic              req,
   input  logic              req_write,
   input  logic              req_long,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ack,
   output logic              busy,
   output logic              tank_out,
   output logic              tank_clr,
   output logic              tank_in,
   output logic [4:0]        digit,
   output logic [ADDR_W-1:0] minor_cycle,
   output logic              monitor_sync
);

   localparam logic [4:0]        DIGIT_LAST = 5'(WORD_BITS - 1);
   localparam logic [ADDR_W-1:0] SLOT_LAST  = ADDR_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              long_q;

   logic              digit_last;
   logic              slot_last;
   logic [ADDR_W-1:0] eff_addr;
   logic [ADDR_W-1:0] end_slot;
   logic              write_nxt;
   logic              xfer_nxt;
   logic              out_nxt;
   logic              clr_nxt;
   logic              in_nxt;
   logic              ack_nxt;
   logic              busy_nxt;

   // Slot preceding a, modulo the circulation.
   function automatic logic [ADDR_W-1:0] prev_slot(input logic [ADDR_W-1:0] a);
      return (a == '0) ? SLOT_LAST : a - ADDR_W'(1);
   endfunction

   // True in the last digit of the slot before a: the next cycle reads (a,0).
   function automatic logic at_pre(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] slot,
                                   input logic              last);
      return last && (slot == prev_slot(a));
   endfunction

   assign digit_last = (digit == DIGIT_LAST);
   assign slot_last  = (minor_cycle == SLOT_LAST);
   assign eff_addr   = req_long ? {req_addr[ADDR_W-1:1], 1'b0} : req_addr;
   assign end_slot   = long_q ? (addr_q | ADDR_W'(1)) : addr_q;

   // Circulation position counters
   always_ff @(posedge f1_clk) begin
      if (f1_rst) begin
         digit       <= '0;
         minor_cycle <= '0;
      end else if (digit_last) begin
         digit       <= '0;
         minor_cycle <= slot_last ? '0 : minor_cycle + ADDR_W'(1);
      end else begin
         digit <= digit + 5'd1;
      end
   end

   // Request fields are held only from acceptance onward, so no reset is needed
   always_ff @(posedge f1_clk) begin
      if (state == IDLE && req) begin
         addr_q  <= eff_addr;
         write_q <= req_write;
         long_q  <= req_long;
      end
   end

   always_comb begin
      state_nxt = state;
      write_nxt = write_q;
      case (state)
         IDLE: begin
            write_nxt = req_write;
            // A request sampled just before its slot skips WAIT entirely
            if (req) begin
               state_nxt = at_pre(eff_addr, minor_cycle, digit_last) ? XFER : WAIT;
            end
         end
         WAIT: begin
            if (at_pre(addr_q, minor_cycle, digit_last)) begin
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (digit_last && minor_cycle == end_slot) begin
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      xfer_nxt = (state_nxt == XFER);
      out_nxt  = xfer_nxt && !write_nxt;
      clr_nxt  = xfer_nxt && write_nxt;
      in_nxt   = xfer_nxt && write_nxt;
      ack_nxt  = (state_nxt == DONE);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge f1_clk) begin
      if (f1_rst) begin
         state    <= IDLE;
         req_ack  <= 1'b0;
         busy     <= 1'b0;
         tank_out <= 1'b0;
         tank_clr <= 1'b0;
         tank_in  <= 1'b0;
      end else begin
         state    <= state_nxt;
         req_ack  <= ack_nxt;
         busy     <= busy_nxt;
         tank_out <= out_nxt;
         tank_clr <= clr_nxt;
         tank_in  <= in_nxt;
      end
   end

`ifdef MEM_SEQ_MONITOR_EN
   logic monitor_q;

   // Reset lands the counters on (0,0), which is itself the sync position
   always_ff @(posedge f1_clk) begin
      if (f1_rst) begin
         monitor_q <= 1'b1;
      end else begin
         monitor_q <= digit_last && slot_last;
      end
   end

   assign monitor_sync = monitor_q;
`else
   assign monitor_sync = 1'b0;
`endif

endmodule

// File: tb/tb_memory_tank_sequencer.sv
// Randomized self-checking bench for memory_tank_sequencer against a time-based reference model.
module tb_memory_tank_sequencer;

   localparam int WORD_BITS = 18;
   localparam int WORDS     = 32;
   localparam int ADDR_W    = 5;
   localparam int CIRC      = WORD_BITS * WORDS;

   logic              f1_clk    = 1'b0;
   logic              f1_rst    = 1'b1;
   logic              req       = 1'b0;
   logic              req_write = 1'b0;
   logic              req_long  = 1'b0;
   logic [ADDR_W-1:0] req_addr  = '0;
   logic              req_ack;
   logic              busy;
   logic              tank_out;
   logic              tank_clr;
   logic              tank_in;
   logic [4:0]        digit;
   logic [ADDR_W-1:0] minor_cycle;
   logic              monitor_sync;

   memory_tank_sequencer #(
      .WORD_BITS(WORD_BITS),
      .WORDS    (WORDS),
      .ADDR_W   (ADDR_W)
   ) dut (
      .f1_clk      (f1_clk),
      .f1_rst      (f1_rst),
      .req         (req),
      .req_write   (req_write),
      .req_long    (req_long),
      .req_addr    (req_addr),
      .req_ack     (req_ack),
      .busy        (busy),
      .tank_out    (tank_out),
      .tank_clr    (tank_clr),
      .tank_in     (tank_in),
      .digit       (digit),
      .minor_cycle (minor_cycle),
      .monitor_sync(monitor_sync)
   );

   always #5 f1_clk = ~f1_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: t counts cycles since reset; one accepted transfer at a time
   int t      = 0;
   bit active = 1'b0;
   int ts     = 0;
   int ws     = 0;
   int wlen   = 0;
   int end_t  = 0;
   bit m_write = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0d got=%h want=%h", tag, t, got, want);
      end
   endtask

   function automatic bit model_idle();
      return !active || t > end_t;
   endfunction

   function automatic logic [31:0] want_ctrl();
      bit g, ack, bsy, mon;
      g   = active && t >= ws && t < ws + wlen;
      ack = active && t == end_t;
      bsy = active && t > ts && t <= end_t;
`ifdef MEM_SEQ_MONITOR_EN
      mon = (t % CIRC) == 0;
`else
      mon = 1'b0;
`endif
      return {26'd0, bsy, ack, g && !m_write, g && m_write, g && m_write, mon};
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_cnt"}, {22'd0, digit, minor_cycle},
            {22'd0, 5'(t % WORD_BITS), ADDR_W'((t / WORD_BITS) % WORDS)});
      check({tag, "_ctl"}, {26'd0, busy, req_ack, tank_out, tank_clr, tank_in, monitor_sync},
            want_ctrl());
   endtask

   task automatic tick();
      int a, start, d;
      @(posedge f1_clk);
      if (req && model_idle()) begin
         a = int'(req_addr);
         if (req_long) a = a & ~1;
         active  = 1'b1;
         ts      = t;
         m_write = req_write;
         wlen    = req_long ? 2 * WORD_BITS : WORD_BITS;
         start   = a * WORD_BITS;
         d       = (start - ((t + 1) % CIRC) + CIRC) % CIRC;
         ws      = t + 1 + d;
         end_t   = ws + wlen;
      end
      t++;
      @(negedge f1_clk);
      check_all("cyc");
   endtask

   task automatic do_reset();
      f1_rst = 1'b1;
      req    = 1'b0;
      @(posedge f1_clk);
      active = 1'b0;
      t      = 0;
      @(negedge f1_clk);
      check_all("rst");
      f1_rst = 1'b0;
   endtask

   task automatic scramble();
      req_write = 1'($urandom);
      req_long  = 1'($urandom);
      req_addr  = ADDR_W'($urandom);
   endtask

   task automatic issue(input bit w, input bit l, input int a);
      req       = 1'b1;
      req_write = w;
      req_long  = l;
      req_addr  = ADDR_W'(a);
      tick();
      req = 1'b0;
      scramble();
   endtask

   task automatic run_to_idle();
      while (!model_idle()) tick();
   endtask

   task automatic wait_phase(input int m);
      while (!(model_idle() && (t % CIRC) == m)) tick();
   endtask

   initial begin
      do_reset();
      // Read addr 5 sampled at (0,3)
      while (t < 3) tick();
      issue(1'b0, 1'b0, 5);
      run_to_idle();
      tick();
      // Long write addr 7 (forced to 6)
      issue(1'b1, 1'b1, 7);
      run_to_idle();
      tick();
      // Window-start boundaries for addr 5
      wait_phase(4 * WORD_BITS + WORD_BITS - 1);
      issue(1'b0, 1'b0, 5);
      run_to_idle();
      wait_phase(5 * WORD_BITS);
      issue(1'b0, 1'b0, 5);
      run_to_idle();
      // Wrap-around cases: single at 31, long at 30
      issue(1'b0, 1'b0, 31);
      run_to_idle();
      tick();
      issue(1'b1, 1'b1, 31);
      run_to_idle();
      tick();
      // Requests while busy are ignored
      issue(1'b0, 1'b0, 3);
      while (t <= end_t) begin
         req       = 1'b1;
         req_write = 1'b1;
         req_long  = 1'b1;
         req_addr  = ADDR_W'(20);
         tick();
      end
      req = 1'b0;
      tick();
      // Reset in cycle 10 of a write window
      issue(1'b1, 1'b0, 9);
      while (t < ws + 10) tick();
      do_reset();
      repeat (40) tick();
      // Randomized traffic with requests injected while busy
      repeat (25) begin
         repeat ($urandom_range(0, 30)) begin
            scramble();
            tick();
         end
         issue(1'($urandom), 1'($urandom), int'($urandom_range(0, WORDS - 1)));
         while (!model_idle()) begin
            req = ($urandom_range(0, 3) == 0);
            scramble();
            tick();
         end
         req = 1'b0;
      end
      repeat (CIRC + 5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
